// File: rtl/soc_spram_arb.sv
// soc_spram_arb: CPU wishbone / DMA arbiter for a single-port 32-bit RAM.
// Define SOC_SPRAM_ARB_COLLISION_EN to build the sticky err_collision detector.
module soc_spram_arb #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wb_addr,
    output logic [31:0]   wb_rdata,
    input  logic [31:0]   wb_wdata,
    input  logic [3:0]    wb_wmsk,
    input  logic          wb_we,
    input  logic          wb_cyc,
    output logic          wb_ack,
    input  logic          dma_req,
    output logic          dma_gnt,
    input  logic [15:0]   dma_addr,
    input  logic [31:0]   dma_data,
    input  logic          dma_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic [3:0]    ram_wmsk,
    output logic          ram_we,
    input  logic [31:0]   ram_rdata,
    output logic          err_collision
);
    typedef enum logic [1:0] {ST_CPU, ST_DRAIN, ST_DMA} state_t;

    state_t r_state;
    logic   r_pend;
    logic   w_dma;
    logic   w_issue;
    logic   w_unused;

    assign w_dma    = r_state == ST_DMA;
    assign w_issue  = r_state == ST_CPU && wb_cyc && !wb_ack && !r_pend && !dma_req;
    assign w_unused = &{1'b0, dma_addr};

    // The ack is the cycle after issue, so the pending flag doubles as the ack.
    assign wb_ack    = r_pend;
    assign wb_rdata  = r_pend ? ram_rdata : 32'h0;
    assign dma_gnt   = w_dma;
    assign ram_addr  = w_dma ? dma_addr[AW-1:0] : wb_addr;
    assign ram_wdata = w_dma ? dma_data : wb_wdata;
    assign ram_wmsk  = w_dma ? 4'hF : wb_wmsk;
    assign ram_we    = w_dma ? dma_we : w_issue && wb_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CPU;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= w_issue;
            case (r_state)
                ST_CPU:   if (dma_req) r_state <= r_pend ? ST_DRAIN : ST_DMA;
                ST_DRAIN: r_state <= ST_DMA;
                ST_DMA:   if (!dma_req) r_state <= ST_CPU;
                default:  r_state <= ST_CPU;
            endcase
        end
    end

`ifdef SOC_SPRAM_ARB_COLLISION_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else if (dma_we && !w_dma) r_err <= 1'b1;
    end

    assign err_collision = r_err;
`else
    assign err_collision = 1'b0;
`endif
endmodule
